// File: rtl/toggle_period_detector.sv
// toggle_period_detector: measures the half-period of a toggle input, checks it against COUNT +/- TOL, declares lock and flags timeout
// Ports: i_Clk clock; i_Rst_L synchronous active-low reset; i_Toggle asynchronous toggle input;
//   o_Period last half-period (clocks), o_Period_Valid one-cycle update pulse, o_Match last period in tolerance,
//   o_Locked LOCK_N consecutive matches, o_Timeout no edge for TIMEOUT clocks (sticky until next edge).
// Optional macro GLITCH_FILTER_EN inserts a FILTER_LEN-sample glitch filter after the synchronizer.
module toggle_period_detector #(
  parameter int COUNT = 1000000,
  parameter int TOL = 1000,
  parameter int LOCK_N = 4,
  parameter int TIMEOUT = 2 * COUNT,
  parameter int FILTER_LEN = 4,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_Toggle,
  output logic [W-1:0] o_Period,
  output logic         o_Period_Valid,
  output logic         o_Match,
  output logic         o_Locked,
  output logic         o_Timeout
);
  localparam int LO = (COUNT > TOL) ? COUNT - TOL : 0;
  localparam int HI = COUNT + TOL;
  localparam int MW = $clog2(LOCK_N + 1);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  state_t r_state, w_state;
  logic r_sync1, r_sync2, r_prev;
  logic w_level, w_edge, w_match;
  logic [W-1:0] r_cnt, w_period;
  logic [MW-1:0] r_mcnt, w_mcnt;
  logic w_valid, w_match_o, w_locked, w_timeout;
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_sync1 <= i_Toggle;
      r_sync2 <= r_sync1;
      r_prev <= w_level;
    end
  end
`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic r_filt;
  logic [FW-1:0] r_fcnt;
  // r_fcnt counts consecutive samples disagreeing with r_filt; the level flips on the FILTER_LEN-th one
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
      r_filt <= r_sync2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end
  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif
  assign w_edge = w_level ^ r_prev;
  assign w_match = ({1'b0, r_cnt} >= (W + 1)'(LO)) && ({1'b0, r_cnt} <= (W + 1)'(HI));
  // counter saturates at TIMEOUT so a stopped input never wraps into a false period
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) r_cnt <= '0;
    else if (w_edge) r_cnt <= W'(1);
    else if (r_cnt != W'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
  end
  // an edge takes priority over timeout, so a period of exactly TIMEOUT is reported as a mismatch
  always_comb begin
    w_state = r_state;
    w_period = o_Period;
    w_valid = 1'b0;
    w_match_o = o_Match;
    w_locked = o_Locked;
    w_timeout = o_Timeout;
    w_mcnt = r_mcnt;
    if (r_state == IDLE) begin
      if (w_edge) begin
        w_state = MEASURE;
        w_timeout = 1'b0;
      end
    end else if (w_edge) begin
      w_period = r_cnt;
      w_valid = 1'b1;
      w_match_o = w_match;
      w_mcnt = !w_match ? '0 : (r_mcnt == MW'(LOCK_N)) ? r_mcnt : r_mcnt + 1'b1;
      w_locked = (w_mcnt == MW'(LOCK_N));
      w_state = w_locked ? LOCKED : MEASURE;
    end else if (r_cnt == W'(TIMEOUT)) begin
      w_state = IDLE;
      w_timeout = 1'b1;
      w_locked = 1'b0;
      w_match_o = 1'b0;
      w_mcnt = '0;
    end
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state <= IDLE;
      r_mcnt <= '0;
      o_Period <= '0;
      o_Period_Valid <= 1'b0;
      o_Match <= 1'b0;
      o_Locked <= 1'b0;
      o_Timeout <= 1'b0;
    end else begin
      r_state <= w_state;
      r_mcnt <= w_mcnt;
      o_Period <= w_period;
      o_Period_Valid <= w_valid;
      o_Match <= w_match_o;
      o_Locked <= w_locked;
      o_Timeout <= w_timeout;
    end
  end
endmodule

// File: tb/tb_toggle_period_detector.sv
// tb_toggle_period_detector: directed self-checking bench for toggle_period_detector
module tb_toggle_period_detector;
  localparam int W = $clog2(26);
  logic clk = 1'b0, rst_l = 1'b0, tog = 1'b0;
  logic [W-1:0] period;
  logic valid, match, locked, timeout;
  int tests = 0, fails = 0, cyc = 0, last_valid_cyc = 0, to_rise_cyc = 0, to_rises = 0;
  logic prev_to = 1'b0;
  typedef struct {int p; bit m; bit l;} vrec_t;
  vrec_t q[$];

  toggle_period_detector #(.COUNT(10), .TOL(1), .LOCK_N(3), .TIMEOUT(25), .FILTER_LEN(4)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Toggle(tog), .o_Period(period), .o_Period_Valid(valid),
    .o_Match(match), .o_Locked(locked), .o_Timeout(timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      q.push_back('{int'(period), match, locked});
      last_valid_cyc = cyc;
    end
    if (timeout === 1'b1 && prev_to !== 1'b1) begin
      to_rise_cyc = cyc;
      to_rises++;
    end
    prev_to = timeout;
  end

  task automatic toggle_after(input int n);
    repeat (n) @(posedge clk);
    #1 tog = ~tog;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    tog = 1'b0;
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;
    q.delete();
  endtask

  task automatic check_q(input string name, input int n, input int ep[6], input bit em[6], input bit el[6]);
    for (int i = 0; i < n; i++) begin
      vrec_t r;
      r = '{-1, 1'b0, 1'b0};
      if (q.size() > 0) r = q.pop_front();
      tests++;
      if (r.p !== ep[i] || r.m !== em[i] || r.l !== el[i]) begin
        fails++;
        $display("FAIL %s[%0d]: got p=%0d m=%0b l=%0b, want p=%0d m=%0b l=%0b", name, i, r.p, r.m, r.l, ep[i], em[i], el[i]);
      end
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_extra: got %0d extra valid pulses, want 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (i % 3 == 0) tog = ~tog;
      @(negedge clk);
      tests++;
      if ({period, valid, match, locked, timeout} !== '0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got p=%0d v=%0b m=%0b l=%0b t=%0b, want all 0", i, period, valid, match, locked, timeout);
      end
    end
    tog = 1'b1;
    @(posedge clk);
    #1 rst_l = 1'b1;
    q.delete();
    repeat (8) @(posedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL reset_first_edge: got %0d valid pulses, want 0", q.size());
    end
    toggle_after(1);
    settle();
    tests++;
    if (q.size() != 1) begin
      fails++;
      $display("FAIL reset_second_edge: got %0d valid pulses, want 1", q.size());
    end
    q.delete();
  endtask

  task automatic test_lock();
    do_reset();
    toggle_after(2);
    repeat (5) toggle_after(10);
    settle();
    check_q("lock", 5, '{10, 10, 10, 10, 10, 0}, '{1, 1, 1, 1, 1, 0}, '{0, 0, 1, 1, 1, 0});
  endtask

  task automatic test_unlock();
    toggle_after(5);
    repeat (3) toggle_after(10);
    settle();
    check_q("unlock", 4, '{13, 10, 10, 10, 0, 0}, '{0, 1, 1, 1, 0, 0}, '{0, 0, 0, 1, 0, 0});
  endtask

  task automatic test_timeout();
    repeat (30) @(posedge clk);
    @(negedge clk);
    tests++;
    if (timeout !== 1'b1 || locked !== 1'b0 || match !== 1'b0 || period !== W'(10)) begin
      fails++;
      $display("FAIL timeout_state: got t=%0b l=%0b m=%0b p=%0d, want t=1 l=0 m=0 p=10", timeout, locked, match, period);
    end
    tests++;
    if (to_rise_cyc - last_valid_cyc != 25) begin
      fails++;
      $display("FAIL timeout_delay: got %0d clocks, want 25", to_rise_cyc - last_valid_cyc);
    end
    toggle_after(1);
    settle();
    tests++;
    if (timeout !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL timeout_clear: got t=%0b valids=%0d, want t=0 valids=0", timeout, q.size());
    end
  endtask

  task automatic test_tolerance();
    int rises;
    rises = to_rises;
    toggle_after(1);
    toggle_after(11);
    toggle_after(8);
    toggle_after(12);
    toggle_after(25);
    settle();
    check_q("tol", 5, '{9, 11, 8, 12, 25, 0}, '{1, 1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
    tests++;
    if (to_rises != rises || timeout !== 1'b0) begin
      fails++;
      $display("FAIL edge_at_timeout: got %0d timeout rises t=%0b, want 0 rises t=0", to_rises - rises, timeout);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    toggle_after(2);
    repeat (3) toggle_after(10);
    toggle_after(4);
    toggle_after(2);
    toggle_after(4);
    settle();
`ifdef GLITCH_FILTER_EN
    check_q("glitch", 4, '{10, 10, 10, 10, 0, 0}, '{1, 1, 1, 1, 0, 0}, '{0, 0, 1, 1, 0, 0});
`else
    check_q("glitch", 6, '{10, 10, 10, 4, 2, 4}, '{1, 1, 1, 0, 0, 0}, '{0, 0, 1, 0, 0, 0});
`endif
  endtask

  initial begin
    test_reset();
    test_lock();
    test_unlock();
    test_timeout();
    test_tolerance();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
